// File: rtl/lavatory_arbiter.sv
// Three-stall lavatory arbiter: stall 0 women-only, stalls 1-2 shared, each stall cycling FREE -> OCCUPIED -> CLEAN.
// Define LAV_TIMEOUT_EN to add per-stall occupancy timeout with a one-cycle alarm pulse.
module lavatory_arbiter #(
    parameter int CLEAN_CYCLES   = 4,
    parameter int WAIT_BITS      = 4,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 req_f,
    input  logic                 req_m,
    // "release" is a reserved word in SystemVerilog, hence the longer name
    input  logic [2:0]           release_pulse,
    output logic [1:0]           gnt_f_stall,
    output logic [1:0]           gnt_m_stall,
    output logic [2:0]           occupied,
    output logic [2:0]           cleaning,
    output logic                 free_f,
    output logic                 free_m,
    output logic [WAIT_BITS-1:0] wait_f,
    output logic [WAIT_BITS-1:0] wait_m,
    output logic [2:0]           alarm
);
    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_OCC   = 2'd1,
        ST_CLEAN = 2'd2
    } stall_state_t;

    typedef enum logic {
        SERVED_F = 1'b0,
        SERVED_M = 1'b1
    } served_t;

    localparam int                   CW         = (CLEAN_CYCLES > 1) ? $clog2(CLEAN_CYCLES) : 1;
    localparam logic [CW-1:0]        CLEAN_LOAD = CW'(CLEAN_CYCLES - 1);
    localparam logic [WAIT_BITS-1:0] WAIT_MAX   = {WAIT_BITS{1'b1}};

    stall_state_t  state_r     [3];
    stall_state_t  state_nx_s  [3];
    logic [CW-1:0] clean_cnt_r [3];
    logic [CW-1:0] clean_nx_s  [3];
    served_t       last_served_r;
    served_t       last_served_nx_s;

    logic [2:0] free_s;
    logic [2:0] take_f_s;
    logic [2:0] take_m_s;
    logic [2:0] timeout_s;
    logic [2:0] alarm_nx_s;
    logic       elig_f_s;
    logic       elig_m_s;
    logic       conflict_s;

    function automatic logic [1:0] stall_code(input logic [2:0] onehot);
        logic [1:0] code;
        case (onehot)
            3'b001:  code = 2'd1;
            3'b010:  code = 2'd2;
            3'b100:  code = 2'd3;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

    // Status decode straight from the registered stall states
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            free_s[i]   = (state_r[i] == ST_FREE);
            occupied[i] = (state_r[i] == ST_OCC);
            cleaning[i] = (state_r[i] == ST_CLEAN);
        end
        free_f = |free_s;
        free_m = free_s[1] | free_s[2];
    end

    // Grant selection; a requester whose grant is showing this cycle is masked
    always_comb begin
        elig_f_s         = req_f && (gnt_f_stall == 2'd0);
        elig_m_s         = req_m && (gnt_m_stall == 2'd0);
        conflict_s       = elig_f_s && elig_m_s && !free_s[0] && (free_s[1] ^ free_s[2]);
        take_f_s         = 3'b000;
        take_m_s         = 3'b000;
        last_served_nx_s = last_served_r;
        if (conflict_s) begin
            if (last_served_r == SERVED_M) begin
                take_f_s         = {free_s[2], free_s[1], 1'b0};
                last_served_nx_s = SERVED_F;
            end else begin
                take_m_s         = {free_s[2], free_s[1], 1'b0};
                last_served_nx_s = SERVED_M;
            end
        end else begin
            if (elig_f_s) begin
                if (free_s[0]) begin
                    take_f_s = 3'b001;
                end else if (free_s[1]) begin
                    take_f_s = 3'b010;
                end else if (free_s[2]) begin
                    take_f_s = 3'b100;
                end else begin
                    take_f_s = 3'b000;
                end
            end else begin
                take_f_s = 3'b000;
            end
            if (elig_m_s) begin
                if (free_s[1] && !take_f_s[1]) begin
                    take_m_s = 3'b010;
                end else if (free_s[2] && !take_f_s[2]) begin
                    take_m_s = 3'b100;
                end else begin
                    take_m_s = 3'b000;
                end
            end else begin
                take_m_s = 3'b000;
            end
        end
    end

`ifdef LAV_TIMEOUT_EN
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    logic [OW-1:0] occ_cnt_r [3];

    // Occupancy counters preset to 1 so the first occupied cycle already counts
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) occ_cnt_r[i] <= OW'(1);
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (state_r[i] == ST_OCC) begin
                    occ_cnt_r[i] <= occ_cnt_r[i] + OW'(1);
                end else begin
                    occ_cnt_r[i] <= OW'(1);
                end
            end
        end
    end

    // Timeout fires at the end of the last allowed occupied cycle
    always_comb begin
        timeout_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            timeout_s[i] = (state_r[i] == ST_OCC) && (occ_cnt_r[i] == OW'(TIMEOUT_CYCLES));
        end
    end
`else
    // Timeout disabled; the parameter stays in the interface so both builds match
    assign timeout_s = 3'(TIMEOUT_CYCLES) & 3'b000;
`endif

    // Per-stall next state; a release on the timeout edge suppresses the alarm
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_nx_s[i] = state_r[i];
            clean_nx_s[i] = clean_cnt_r[i];
            alarm_nx_s[i] = 1'b0;
            case (state_r[i])
                ST_FREE: begin
                    if (take_f_s[i] || take_m_s[i]) begin
                        state_nx_s[i] = ST_OCC;
                    end else begin
                        state_nx_s[i] = ST_FREE;
                    end
                end
                ST_OCC: begin
                    if (release_pulse[i] || timeout_s[i]) begin
                        state_nx_s[i] = ST_CLEAN;
                        clean_nx_s[i] = CLEAN_LOAD;
                        alarm_nx_s[i] = timeout_s[i] && !release_pulse[i];
                    end else begin
                        state_nx_s[i] = ST_OCC;
                    end
                end
                ST_CLEAN: begin
                    if (clean_cnt_r[i] == {CW{1'b0}}) begin
                        state_nx_s[i] = ST_FREE;
                    end else begin
                        clean_nx_s[i] = clean_cnt_r[i] - CW'(1);
                    end
                end
                default: begin
                    state_nx_s[i] = ST_FREE;
                    clean_nx_s[i] = {CW{1'b0}};
                end
            endcase
        end
    end

    // Stall state, clean counters and fairness memory
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                state_r[i]     <= ST_FREE;
                clean_cnt_r[i] <= {CW{1'b0}};
            end
            last_served_r <= SERVED_M;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_r[i]     <= state_nx_s[i];
                clean_cnt_r[i] <= clean_nx_s[i];
            end
            last_served_r <= last_served_nx_s;
        end
    end

    // Registered grant pulses and alarms
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            gnt_f_stall <= 2'd0;
            gnt_m_stall <= 2'd0;
            alarm       <= 3'b000;
        end else begin
            gnt_f_stall <= stall_code(take_f_s);
            gnt_m_stall <= stall_code(take_m_s);
            alarm       <= alarm_nx_s;
        end
    end

    // Saturating wait counters: clear on grant, count while eligible and unserved
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            wait_f <= {WAIT_BITS{1'b0}};
            wait_m <= {WAIT_BITS{1'b0}};
        end else begin
            if (take_f_s != 3'b000) begin
                wait_f <= {WAIT_BITS{1'b0}};
            end else if (elig_f_s && (wait_f != WAIT_MAX)) begin
                wait_f <= wait_f + {{(WAIT_BITS-1){1'b0}}, 1'b1};
            end else begin
                wait_f <= wait_f;
            end
            if (take_m_s != 3'b000) begin
                wait_m <= {WAIT_BITS{1'b0}};
            end else if (elig_m_s && (wait_m != WAIT_MAX)) begin
                wait_m <= wait_m + {{(WAIT_BITS-1){1'b0}}, 1'b1};
            end else begin
                wait_m <= wait_m;
            end
        end
    end

endmodule
